// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op one-hot indices and FSM encoding shared by the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic             i_div,
  output logic [WIDTH:0]   o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mhi;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;
  assign w_sum  = i_acc_hi + {1'b0, i_opnd};
  assign w_mhi  = i_acc_lo[0] ? w_sum : i_acc_hi;
  assign w_sh   = {i_acc_hi[WIDTH-1:0], i_acc_lo[WIDTH-1]};
  assign w_diff = {1'b0, w_sh} - {2'b00, i_opnd};
  assign o_hi   = i_div ? (w_diff[WIDTH+1] ? w_sh : w_diff[WIDTH:0]) : {1'b0, w_mhi[WIDTH:1]};
  assign o_lo   = i_div ? {i_acc_lo[WIDTH-2:0], ~w_diff[WIDTH+1]} : {w_mhi[0], i_acc_lo[WIDTH-1:1]};
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair,
// with start/busy/done handshake, pipeline cancel and MTHI/MTLO writes.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_acc_hi, w_step_hi;
  logic [WIDTH-1:0]   r_acc_lo, w_step_lo, r_opnd, r_src1, r_hi, r_lo;
  logic               r_div, r_neg_q, r_neg_r, r_dz, r_done, r_dz_pulse;
  logic               w_sgn, w_div_op, w_neg1, w_neg2, w_accept;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_rem_mag, w_quo, w_rem, w_res_hi, w_res_lo;
  assign w_sgn    = op[OP_MULT] | op[OP_DIV];
  assign w_div_op = op[OP_DIV] | op[OP_DIVU];
  assign w_neg1   = w_sgn & src1[WIDTH-1];
  assign w_neg2   = w_sgn & src2[WIDTH-1];
  assign w_mag1   = w_neg1 ? -src1 : src1;
  assign w_mag2   = w_neg2 ? -src2 : src2;
  assign w_accept = (r_state == IDLE) && start && !cancel && is_onehot(op);
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc_hi(r_acc_hi),
    .i_acc_lo(r_acc_lo),
    .i_opnd  (r_opnd),
    .i_div   (r_div),
    .o_hi    (w_step_hi),
    .o_lo    (w_step_lo)
  );
  // Work on magnitudes; signs are restored once in FIX.
  assign w_prod    = {r_acc_hi[WIDTH-1:0], r_acc_lo};
  assign w_prod_s  = r_neg_q ? -w_prod : w_prod;
  assign w_rem_mag = r_acc_hi[WIDTH-1:0];
  assign w_quo     = r_neg_q ? -r_acc_lo : r_acc_lo;
  assign w_rem     = r_neg_r ? -w_rem_mag : w_rem_mag;
  assign w_res_hi  = !r_div ? w_prod_s[2*WIDTH-1:WIDTH] : r_dz ? r_src1 : w_rem;
  assign w_res_lo  = !r_div ? w_prod_s[WIDTH-1:0] : r_dz ? '1 : w_quo;
  always_comb begin
    w_next = r_state;
    if (cancel) w_next = IDLE;
    else if (r_state == IDLE && w_accept) w_next = CALC;
    else if (r_state == CALC && r_cnt == CNT_W'(1)) w_next = FIX;
    else if (r_state == FIX) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd <= '0;
      r_src1 <= '0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_done <= 1'b0;
      r_dz_pulse <= 1'b0;
    end else begin
      r_done <= (r_state == FIX) && !cancel;
      r_dz_pulse <= (r_state == FIX) && !cancel && r_dz;
      if (r_state == IDLE) begin
        if (hi_wen) r_hi <= hilo_wdata;
        if (lo_wen) r_lo <= hilo_wdata;
        if (w_accept) begin
          r_cnt <= CNT_W'(WIDTH);
          r_acc_hi <= '0;
          r_acc_lo <= w_div_op ? w_mag1 : w_mag2;
          r_opnd <= w_div_op ? w_mag2 : w_mag1;
          r_src1 <= src1;
          r_div <= w_div_op;
          r_neg_q <= w_neg1 ^ w_neg2;
          r_neg_r <= w_neg1;
          r_dz <= w_div_op && (src2 == '0);
        end
      end else if (r_state == CALC) begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (!cancel) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end
  assign busy        = r_state != IDLE;
  assign done        = r_done;
  assign div_by_zero = r_dz_pulse;
  assign hi          = r_hi;
  assign lo          = r_lo;
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU from the EX stage through a start/busy/done handshake.
- Accepts MTHI/MTLO direct writes.
- Supplies HI_data/LO_data to the write-back data mux inputs, which are currently tied to zero.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch operation (EX stage)
- op  in  4  one-hot [mult, multu, div, divu]
- src1  in  WIDTH  rs data (multiplicand / dividend)
- src2  in  WIDTH  rt data (multiplier / divisor)
- cancel  in  1  pipeline flush; aborts the in-flight operation
- hi_wen  in  1  MTHI write enable
- lo_wen  in  1  MTLO write enable
- hilo_wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight; pipeline must stall a dependent MFHI/MFLO/muldiv
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  out  1  one-cycle pulse coincident with done, div/divu only
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high: all state clears immediately. busy=0, done=0, div_by_zero=0, hi=0, lo=0, FSM=IDLE. A reset mid-operation discards the operation.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1, op exactly one-hot and cancel=0 → capture on that edge: operand magnitudes, result signs, original src1, op, divisor-zero flag. counter=WIDTH. Go to CALC.
  - op zero or multi-hot → start ignored, stay in IDLE.
- CALC:
  - One radix-2 step per edge: shift-add for multiply, restoring subtract for divide. counter decrements.
  - After WIDTH steps, go to FIX.
- FIX:
  - Apply sign correction and write HI/LO. Return to IDLE.
  - done and div_by_zero are registered: high for exactly the one cycle after the FIX edge.
- Latency: start edge = edge 0. HI/LO and done are visible after edge WIDTH+1. busy is high from after edge 0 through the FIX edge, and low in the done cycle. A new start is legal in the done cycle.
- mult/multu: {hi,lo} = 2*WIDTH-bit product, signed or unsigned.
- div/divu: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero. Signed remainder takes the sign of the dividend.
  - MIN / -1 → lo = MIN, hi = 0 (natural wrap, no exception).
- Divisor zero: full latency still taken. lo = all ones, hi = original src1, div_by_zero pulses with done.
- start while busy: ignored; no queueing.
- cancel:
  - In CALC or FIX → IDLE on the next edge. HI/LO unchanged, no done.
  - In IDLE together with start → cancel wins, start ignored.
- hi_wen/lo_wen:
  - Honoured only when busy=0; the write takes effect on the edge.
  - While busy they are ignored; the hazard unit guarantees the stall.
  - A direct write in the same cycle as an accepted start is applied; the later result overwrites it.
  - hi_wen and lo_wen together write hilo_wdata to both registers.

Decomposition:
- Shared package muldiv_pkg:
  - op one-hot bit indices: OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3.
  - FSM state encoding: IDLE, CALC, FIX.
- Sub-module muldiv_step (combinational, parametrised WIDTH). It takes the partial accumulator, operand and mode, and returns the next accumulator/quotient bits for one iteration. Instantiated once and driven by the FSM.

Test Plan (WIDTH=32):
- multu 0xFFFFFFFF*0xFFFFFFFF → busy for 33 cycles; after edge 33, done=1, hi=0xFFFFFFFE, lo=0x00000001. mult -7*3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 → lo=3, hi=1. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- divu 5/0 → after edge 33, lo=0xFFFFFFFF, hi=5, div_by_zero=1 and done=1 for one cycle only.
- Preload via hi_wen/lo_wen (0x1234/0x5678). Start mult, assert cancel at cycle 10 → IDLE next edge, no done, hi=0x1234, lo=0x5678. A start pulse during busy has no effect. hi_wen during busy has no effect.
- Back-to-back: start a new op in the done cycle → second result is correct, done pulses exactly WIDTH+2 cycles later. start with op=4'b0101 → stays IDLE, busy=0.
- Assert reset asynchronously mid-CALC → busy/done/hi/lo are 0 without waiting for a clk edge. After release, a fresh multu 3*4 → lo=12, hi=0.
